// File: rtl/apb_reg_bank_pkg.sv
// Shared definitions for the APB register bank: register map, STATUS layout
// and the CTRL bit that triggers the start pulse.
package apb_reg_bank_pkg;

    localparam int REG_STATUS = 0;
    localparam int REG_CTRL   = 1;
    localparam int REG_TXDATA = 2;
    localparam int REG_ADDR   = 3;
    localparam int REG_CMD    = 4;
    localparam int REG_RXDATA = 5;

    localparam int ST_TX_FULL      = 0;
    localparam int ST_TX_EMPTY     = 1;
    localparam int ST_RX_FULL      = 2;
    localparam int ST_RX_EMPTY     = 3;
    localparam int ST_TX_OVF       = 4;
    localparam int ST_RX_OVF       = 5;
    localparam int ST_TX_COUNT_LSB = 8;

    localparam int CTRL_START_BIT = 4;

    // The STATUS count field is only 8 bits wide; deeper FIFOs clamp at 255.
    function automatic logic [7:0] sat_u8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/apb_reg_bank_if.sv
// APB bus bundle between a bus master and the register bank.
interface apb_reg_bank_if #(
    parameter int ADDRESSWIDTH = 3,
    parameter int DATAWIDTH    = 16
);
    logic [ADDRESSWIDTH-1:0] PADDR_i;
    logic [DATAWIDTH-1:0]    PWDATA_i;
    logic                    PWRITE_i;
    logic                    PSELx_i;
    logic                    PENABLE_i;
    logic [DATAWIDTH-1:0]    PRDATA_o;
    logic                    PREADY_o;

    modport master (
        output PADDR_i, PWDATA_i, PWRITE_i, PSELx_i, PENABLE_i,
        input  PRDATA_o, PREADY_o
    );

    modport slave (
        input  PADDR_i, PWDATA_i, PWRITE_i, PSELx_i, PENABLE_i,
        output PRDATA_o, PREADY_o
    );
endinterface

// File: rtl/apb_reg_bank_sync_fifo.sv
// Single-clock FIFO with first-word fall-through head; push is refused when
// full (even if a pop happens the same cycle), pop is ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = {{(AW - 1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
        else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/apb_reg_bank.sv
// APB register bank in front of the lift-controller TX/RX core: control,
// address and command registers plus TX and RX word FIFOs.
module apb_reg_bank
    import apb_reg_bank_pkg::*;
#(
    parameter int ADDRESSWIDTH = 3,
    parameter int DATAWIDTH    = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_reg_bank_if.slave        apb,
    output logic [7:0]           ctrl_o,
    output logic [7:0]           cfg_addr_o,
    output logic [15:0]          cfg_cmd_o,
    output logic                 start_o,
    output logic [DATAWIDTH-1:0] tx_data_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    input  logic [DATAWIDTH-1:0] rx_data_i,
    input  logic                 rx_valid_i
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]  ctrl_q, ctrl_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] cmd_q, cmd_d;
    logic        start_q, start_d;
    logic        tx_ovf_q, tx_ovf_d;
    logic        rx_ovf_q, rx_ovf_d;

    logic access, wr_commit, rd_access;
    logic sel_status, sel_ctrl, sel_txdata, sel_addr, sel_cmd, sel_rxdata;

    logic                 tx_push, tx_full, tx_empty;
    logic [CW-1:0]        tx_count;
    logic [DATAWIDTH-1:0] tx_head;
    logic                 rx_pop, rx_full, rx_empty;
    logic [CW-1:0]        rx_count;
    logic [DATAWIDTH-1:0] rx_head;

    logic [15:0]          status_w;
    logic [DATAWIDTH-1:0] rdata;

    assign access       = apb.PSELx_i & apb.PENABLE_i;
    assign apb.PREADY_o = access;
    assign wr_commit    = access & apb.PWRITE_i & apb.PREADY_o;
    assign rd_access    = access & ~apb.PWRITE_i;

    assign sel_status = (apb.PADDR_i == ADDRESSWIDTH'(REG_STATUS));
    assign sel_ctrl   = (apb.PADDR_i == ADDRESSWIDTH'(REG_CTRL));
    assign sel_txdata = (apb.PADDR_i == ADDRESSWIDTH'(REG_TXDATA));
    assign sel_addr   = (apb.PADDR_i == ADDRESSWIDTH'(REG_ADDR));
    assign sel_cmd    = (apb.PADDR_i == ADDRESSWIDTH'(REG_CMD));
    assign sel_rxdata = (apb.PADDR_i == ADDRESSWIDTH'(REG_RXDATA));

    assign tx_push = wr_commit & sel_txdata;
    assign rx_pop  = rd_access & sel_rxdata & (rx_count != '0);

    sync_fifo #(.WIDTH(DATAWIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (tx_push),
        .pop   (tx_ready_i),
        .din   (apb.PWDATA_i),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count),
        .head  (tx_head)
    );

    sync_fifo #(.WIDTH(DATAWIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (rx_valid_i),
        .pop   (rx_pop),
        .din   (rx_data_i),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count),
        .head  (rx_head)
    );

    always_comb begin
        ctrl_d   = ctrl_q;
        addr_d   = addr_q;
        cmd_d    = cmd_q;
        start_d  = 1'b0;
        tx_ovf_d = tx_ovf_q;
        rx_ovf_d = rx_ovf_q;
        if (wr_commit) begin
            if (sel_status) begin
                if (apb.PWDATA_i[ST_TX_OVF]) tx_ovf_d = 1'b0;
                if (apb.PWDATA_i[ST_RX_OVF]) rx_ovf_d = 1'b0;
            end
            if (sel_ctrl) begin
                ctrl_d  = 8'(apb.PWDATA_i);
                start_d = apb.PWDATA_i[CTRL_START_BIT] & ~ctrl_q[CTRL_START_BIT];
            end
            if (sel_addr) addr_d = 8'(apb.PWDATA_i);
            if (sel_cmd)  cmd_d  = 16'(apb.PWDATA_i);
        end
        // A fresh overflow wins over a same-cycle clear so no event is lost.
        if (tx_push && tx_full)    tx_ovf_d = 1'b1;
        if (rx_valid_i && rx_full) rx_ovf_d = 1'b1;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            ctrl_q   <= '0;
            addr_q   <= '0;
            cmd_q    <= '0;
            start_q  <= 1'b0;
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            addr_q   <= addr_d;
            cmd_q    <= cmd_d;
            start_q  <= start_d;
            tx_ovf_q <= tx_ovf_d;
            rx_ovf_q <= rx_ovf_d;
        end
    end

    always_comb begin
        status_w                            = '0;
        status_w[ST_TX_FULL]                = tx_full;
        status_w[ST_TX_EMPTY]               = tx_empty;
        status_w[ST_RX_FULL]                = rx_full;
        status_w[ST_RX_EMPTY]               = rx_empty;
        status_w[ST_TX_OVF]                 = tx_ovf_q;
        status_w[ST_RX_OVF]                 = rx_ovf_q;
        status_w[ST_TX_COUNT_LSB +: 8]      = sat_u8(32'(tx_count));
    end

    // Read data is held at zero during reset and outside the access phase.
    always_comb begin
        rdata = '0;
        if (PRESETn && access) begin
            if (sel_status)      rdata = DATAWIDTH'(status_w);
            else if (sel_ctrl)   rdata = DATAWIDTH'(ctrl_q);
            else if (sel_addr)   rdata = DATAWIDTH'(addr_q);
            else if (sel_cmd)    rdata = DATAWIDTH'(cmd_q);
            else if (sel_rxdata) rdata = rx_head;
        end
    end

    assign apb.PRDATA_o = rdata;
    assign ctrl_o       = ctrl_q;
    assign cfg_addr_o   = addr_q;
    assign cfg_cmd_o    = cmd_q;
    assign start_o      = start_q;
    assign tx_data_o    = tx_head;
    assign tx_valid_o   = ~tx_empty;

endmodule

// File: tb/tb_apb_reg_bank.sv
// Self-checking bench for apb_reg_bank: register table, FIFO corner
// sequences, mid-transfer reset and a randomized run against a queue model.
module tb_apb_reg_bank;
    localparam int AW    = 3;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic [7:0]    ctrl_o, cfg_addr_o;
    logic [15:0]   cfg_cmd_o;
    logic          start_o;
    logic [DW-1:0] tx_data_o;
    logic          tx_valid_o;
    logic          tx_ready_i;
    logic [DW-1:0] rx_data_i;
    logic          rx_valid_i;

    int errors = 0;
    int checks = 0;

    always #5 PCLK = ~PCLK;

    apb_reg_bank_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) apb ();

    apb_reg_bank #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .apb        (apb),
        .ctrl_o     (ctrl_o),
        .cfg_addr_o (cfg_addr_o),
        .cfg_cmd_o  (cfg_cmd_o),
        .start_o    (start_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i)
    );

    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;   // read: expected PRDATA; write: expected start_o
    } vec_t;
    vec_t vecs[$];

    // Reference model state
    logic [7:0]  m_ctrl, m_addr;
    logic [15:0] m_cmd;
    logic [15:0] m_tx[$];
    logic [15:0] m_rx[$];
    bit          m_txovf, m_rxovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        PRESETn = 1'b0;
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        m_ctrl = '0; m_addr = '0; m_cmd = '0;
        m_tx.delete(); m_rx.delete();
        m_txovf = 0; m_rxovf = 0;
    endtask

    task automatic apb_write(input logic [2:0] a, input logic [15:0] d, input bit pop);
        @(posedge PCLK); #1;
        apb.PADDR_i = a; apb.PWDATA_i = d; apb.PWRITE_i = 1'b1;
        apb.PSELx_i = 1'b1; apb.PENABLE_i = 1'b0;
        @(posedge PCLK); #1;
        apb.PENABLE_i = 1'b1; tx_ready_i = pop;
        @(posedge PCLK); #1;
        apb.PSELx_i = 1'b0; apb.PENABLE_i = 1'b0; apb.PWRITE_i = 1'b0; tx_ready_i = 1'b0;
    endtask

    task automatic apb_read(input logic [2:0] a, output logic [15:0] d);
        @(posedge PCLK); #1;
        apb.PADDR_i = a; apb.PWRITE_i = 1'b0; apb.PSELx_i = 1'b1; apb.PENABLE_i = 1'b0;
        @(posedge PCLK); #1;
        apb.PENABLE_i = 1'b1;
        @(negedge PCLK);
        d = apb.PRDATA_o;
        @(posedge PCLK); #1;
        apb.PSELx_i = 1'b0; apb.PENABLE_i = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [15:0] exp);
        logic [15:0] d;
        apb_read(a, d);
        check(name, d, exp);
    endtask

    task automatic rx_push(input logic [15:0] d);
        @(posedge PCLK); #1;
        rx_data_i = d; rx_valid_i = 1'b1;
        @(posedge PCLK); #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic drain_check(input logic [15:0] exp);
        @(posedge PCLK); #1;
        check("drain_valid", tx_valid_o, 1);
        check("drain_data", tx_data_o, exp);
        tx_ready_i = 1'b1;
        @(posedge PCLK); #1;
        tx_ready_i = 1'b0;
    endtask

    function automatic logic [15:0] model_status();
        logic [15:0] s;
        int tc = m_tx.size();
        int rc = m_rx.size();
        s = '0;
        s[0] = (tc == DEPTH);
        s[1] = (tc == 0);
        s[2] = (rc == DEPTH);
        s[3] = (rc == 0);
        s[4] = m_txovf;
        s[5] = m_rxovf;
        s[15:8] = (tc > 255) ? 8'hFF : 8'(tc);
        return s;
    endfunction

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        apb.PADDR_i = '0; apb.PWDATA_i = '0; apb.PWRITE_i = 1'b0;
        apb.PSELx_i = 1'b0; apb.PENABLE_i = 1'b0;
        tx_ready_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = '0;
        do_reset();

        // ---------- register table ----------
        vecs.push_back('{0, 3'd0, 16'h0000, 16'h000A});
        vecs.push_back('{0, 3'd1, 16'h0000, 16'h0000});
        vecs.push_back('{0, 3'd2, 16'h0000, 16'h0000});
        vecs.push_back('{0, 3'd3, 16'h0000, 16'h0000});
        vecs.push_back('{0, 3'd4, 16'h0000, 16'h0000});
        vecs.push_back('{0, 3'd5, 16'h0000, 16'h0000});
        vecs.push_back('{0, 3'd6, 16'h0000, 16'h0000});
        vecs.push_back('{0, 3'd7, 16'h0000, 16'h0000});
        vecs.push_back('{1, 3'd3, 16'hFF05, 16'h0000});
        vecs.push_back('{0, 3'd3, 16'h0000, 16'h0005});
        vecs.push_back('{1, 3'd4, 16'h0001, 16'h0000});
        vecs.push_back('{0, 3'd4, 16'h0000, 16'h0001});
        vecs.push_back('{1, 3'd1, 16'hABE0, 16'h0000});
        vecs.push_back('{0, 3'd1, 16'h0000, 16'h00E0});
        vecs.push_back('{1, 3'd1, 16'h00F0, 16'h0001});
        vecs.push_back('{0, 3'd1, 16'h0000, 16'h00F0});
        vecs.push_back('{1, 3'd1, 16'h00F0, 16'h0000});
        vecs.push_back('{1, 3'd1, 16'h00E0, 16'h0000});
        vecs.push_back('{1, 3'd6, 16'h1234, 16'h0000});
        vecs.push_back('{0, 3'd6, 16'h0000, 16'h0000});
        vecs.push_back('{0, 3'd0, 16'h0000, 16'h000A});

        check("reset_tx_valid", tx_valid_o, 0);
        check("reset_tx_data", tx_data_o, 0);
        check("reset_start", start_o, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].data, 1'b0);
                check($sformatf("vec%0d_start", i), start_o, vecs[i].exp);
                @(posedge PCLK); #1;
                check($sformatf("vec%0d_start_gone", i), start_o, 0);
            end else begin
                apb_read(vecs[i].addr, d);
                check($sformatf("vec%0d_read", i), d, vecs[i].exp);
            end
        end
        check("ctrl_o", ctrl_o, 8'hE0);
        check("cfg_addr_o", cfg_addr_o, 8'h05);
        check("cfg_cmd_o", cfg_cmd_o, 16'h0001);

        // ---------- TX overflow and drain ----------
        for (int i = 1; i <= 18; i++) begin
            apb_write(3'd2, 16'(i), 1'b0);
            if (i == 1) check("tx_valid_after_push", tx_valid_o, 1);
        end
        read_check("tx_full_status", 3'd0, 16'h1019);
        for (int i = 1; i <= 16; i++) drain_check(16'(i));
        @(posedge PCLK); #1;
        check("tx_valid_drained", tx_valid_o, 0);
        read_check("tx_ovf_still_set", 3'd0, 16'h001A);
        apb_write(3'd0, 16'h0010, 1'b0);
        read_check("tx_ovf_cleared", 3'd0, 16'h000A);

        // full + simultaneous pop: push rejected; not full + pop: both happen
        for (int i = 1; i <= 16; i++) apb_write(3'd2, 16'h0100 + 16'(i), 1'b0);
        apb_write(3'd2, 16'h01FF, 1'b1);
        read_check("full_push_pop", 3'd0, 16'h0F18);
        apb_write(3'd0, 16'h0010, 1'b0);
        apb_write(3'd2, 16'h02AA, 1'b1);
        read_check("push_pop_same", 3'd0, 16'h0F08);
        for (int i = 3; i <= 16; i++) drain_check(16'h0100 + 16'(i));
        drain_check(16'h02AA);

        // ---------- RX path ----------
        rx_push(16'hAAAA);
        read_check("rx_not_empty", 3'd0, 16'h0002);
        rx_push(16'h5555);
        read_check("rx_pop0", 3'd5, 16'hAAAA);
        read_check("rx_pop1", 3'd5, 16'h5555);
        read_check("rx_pop_empty", 3'd5, 16'h0000);
        read_check("rx_empty_status", 3'd0, 16'h000A);
        for (int i = 0; i < 17; i++) rx_push(16'h0300 + 16'(i));
        read_check("rx_ovf_status", 3'd0, 16'h0026);
        apb_write(3'd0, 16'h0030, 1'b0);
        read_check("rx_ovf_cleared", 3'd0, 16'h0006);
        read_check("rx_ovf_head", 3'd5, 16'h0300);

        // ---------- reset in the middle of a TX burst ----------
        do_reset();
        apb_write(3'd1, 16'h00F0, 1'b0);
        apb_write(3'd3, 16'h0033, 1'b0);
        apb_write(3'd4, 16'hBEEF, 1'b0);
        for (int i = 0; i < 5; i++) apb_write(3'd2, 16'h0400 + 16'(i), 1'b0);
        @(posedge PCLK); #1;
        apb.PADDR_i = 3'd2; apb.PWDATA_i = 16'h0499; apb.PWRITE_i = 1'b1;
        apb.PSELx_i = 1'b1; apb.PENABLE_i = 1'b0;
        @(posedge PCLK); #1;
        apb.PENABLE_i = 1'b1; PRESETn = 1'b0;
        @(negedge PCLK);
        check("rst_pready", apb.PREADY_o, 1);
        @(posedge PCLK); #1;
        apb.PSELx_i = 1'b0; apb.PENABLE_i = 1'b0; apb.PWRITE_i = 1'b0;
        check("rst_tx_valid", tx_valid_o, 0);
        check("rst_tx_data", tx_data_o, 0);
        check("rst_ctrl", ctrl_o, 0);
        check("rst_addr", cfg_addr_o, 0);
        check("rst_cmd", cfg_cmd_o, 0);
        check("rst_start", start_o, 0);
        PRESETn = 1'b1;
        read_check("rst_status", 3'd0, 16'h000A);
        m_ctrl = '0; m_addr = '0; m_cmd = '0;
        m_tx.delete(); m_rx.delete(); m_txovf = 0; m_rxovf = 0;

        // ---------- randomized run against the queue model ----------
        for (int n = 0; n < 400; n++) begin
            int op;
            logic [2:0]  a;
            logic [15:0] wd, exp_rd;
            bit          exp_start;
            op = $urandom_range(0, 9);
            wd = 16'($urandom);
            if (op <= 2) begin
                a = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'($urandom_range(0, 7));
                exp_start = 0;
                case (a)
                    3'd0: begin
                        if (wd[4]) m_txovf = 0;
                        if (wd[5]) m_rxovf = 0;
                    end
                    3'd1: begin
                        exp_start = wd[4] & ~m_ctrl[4];
                        m_ctrl = wd[7:0];
                    end
                    3'd2: if (m_tx.size() < DEPTH) m_tx.push_back(wd); else m_txovf = 1;
                    3'd3: m_addr = wd[7:0];
                    3'd4: m_cmd = wd;
                    default: ;
                endcase
                apb_write(a, wd, 1'b0);
                check("rnd_start", start_o, exp_start);
            end else if (op <= 4) begin
                a = ($urandom_range(0, 1) == 0) ? 3'(5 * $urandom_range(0, 1)) : 3'($urandom_range(0, 7));
                case (a)
                    3'd0: exp_rd = model_status();
                    3'd1: exp_rd = 16'(m_ctrl);
                    3'd3: exp_rd = 16'(m_addr);
                    3'd4: exp_rd = m_cmd;
                    3'd5: exp_rd = (m_rx.size() > 0) ? m_rx.pop_front() : 16'h0000;
                    default: exp_rd = 16'h0000;
                endcase
                read_check($sformatf("rnd_read_a%0d", a), a, exp_rd);
            end else if (op <= 6) begin
                if (m_rx.size() < DEPTH) m_rx.push_back(wd); else m_rxovf = 1;
                rx_push(wd);
            end else if (op <= 8) begin
                @(posedge PCLK); #1;
                check("rnd_tx_valid", tx_valid_o, m_tx.size() != 0);
                if (m_tx.size() != 0) check("rnd_tx_data", tx_data_o, m_tx.pop_front());
                tx_ready_i = 1'b1;
                @(posedge PCLK); #1;
                tx_ready_i = 1'b0;
            end else begin
                @(posedge PCLK); #1;
                check("rnd_ctrl", ctrl_o, m_ctrl);
                check("rnd_addr", cfg_addr_o, m_addr);
                check("rnd_cmd", cfg_cmd_o, m_cmd);
            end
        end
        read_check("rnd_final_status", 3'd0, model_status());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_reg_bank.md
# apb_reg_bank

APB slave register bank that sits directly upstream of the lift-controller transmit/receive core. It decodes APB accesses on PCLK, holds the control, address and command registers, and buffers transmit words in a TX FIFO and received words in an RX FIFO. The core consumes TX words and produces RX words through valid/ready handshakes on the same clock.

## Interface
- ADDRESSWIDTH, 3, APB address width
- DATAWIDTH, 16, APB data width and FIFO word width
- FIFO_DEPTH, 16, entries per FIFO (power of 2, ≥2)

- PCLK  in  1  system clock, all logic rising-edge
- PRESETn  in  1  one clock; reset is synchronous and active-low
- PADDR_i  in  ADDRESSWIDTH  register address
- PWDATA_i  in  DATAWIDTH  write data
- PWRITE_i  in  1  1=write
- PSELx_i  in  1  slave select
- PENABLE_i  in  1  access phase
- PRDATA_o  out  DATAWIDTH  read data, valid while PREADY_o=1
- PREADY_o  out  1  transfer complete
- ctrl_o  out  8  control register
- cfg_addr_o  out  8  target/address register
- cfg_cmd_o  out  16  command register
- start_o  out  1  one-cycle start pulse
- tx_data_o  out  DATAWIDTH  TX FIFO head (first-word fall-through)
- tx_valid_o  out  1  TX FIFO not empty
- tx_ready_i  in  1  core pops head when tx_valid_o & tx_ready_i
- rx_data_i  in  DATAWIDTH  received word
- rx_valid_i  in  1  push rx_data_i this cycle

## Operation
- Register map: 0 STATUS (RO, W1C bits), 1 CTRL (RW, bits[7:0]), 2 TXDATA (WO, push), 3 ADDR (RW, bits[7:0]), 4 CMD (RW, 16 bits), 5 RXDATA (RO, pop); 6–7 unmapped (read 0, writes ignored).
- STATUS: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_ovf, [5] rx_ovf, [15:8] tx_count (saturates display at 255). Writing 1 to bit 4/5 clears that flag.
- Write commit: PSELx_i & PENABLE_i & PWRITE_i & PREADY_o. Read: PSELx_i & PENABLE_i & ~PWRITE_i.
- Upper unused PWDATA_i bits ignored; 8-bit registers read back zero-extended.
- start_o: asserted for one cycle after a CTRL write where new bit 4 = 1 and old bit 4 = 0.
- TXDATA write when TX full: word dropped, tx_ovf set. Push and pop same cycle when not full: both occur, count unchanged. Full with simultaneous pop: push still rejected.
- RX push when full: word dropped, rx_ovf set. RXDATA read when empty: returns 0, no pop, no flag.
- Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.

## Timing
- Zero wait states: PREADY_o = PSELx_i & PENABLE_i (combinational).
- PRDATA_o combinational from registers/FIFO head during access phase, 0 otherwise.
- Register write visible on outputs the cycle after commit; start_o high that same cycle.
- TX push at commit edge → tx_valid_o high next cycle. RX push → STATUS rx_empty=0 next cycle.
- RXDATA read pops at the access-phase edge; next read sees next word.
- Reset (any cycle, including mid-transfer): ctrl_o, cfg_addr_o, cfg_cmd_o = 0; start_o=0; both FIFOs empty; ovf flags 0; tx_valid_o=0; tx_data_o=0; PRDATA_o=0. PREADY_o follows its equation.

## Structure
- Shared package: register address constants (REG_STATUS..REG_RXDATA), STATUS bit indices, CTRL_START_BIT=4.
- Sub-module sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count/head), instantiated twice.

## Test plan
- Reset then read all registers → STATUS=0x000A, all others 0, tx_valid_o=0.
- Write ADDR=0x05, CMD=0x0001, CTRL=0xE0 → readback 0x0005/0x0001/0x00E0; no start_o.
- CTRL 0xE0 → 0xF0 → start_o one cycle; 0xF0 rewritten → no pulse; 0xE0 → no pulse.
- Push 0x001..0x012 (18 words, depth 16) with tx_ready_i=0 → tx_full, tx_ovf=1, count 16; drain with tx_ready_i=1 → 0x001..0x010 in order, then tx_valid_o=0; W1C bit 4 clears tx_ovf.
- Drive rx 0xAAAA, 0x5555; read RXDATA ×3 → 0xAAAA, 0x5555, 0x0000; rx_empty=1.
- Assert PRESETn=0 mid-TX burst with 5 words queued → next cycle FIFO empty, tx_valid_o=0, registers 0.
